// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read and write controllers.
// Provides the default geometry and the Gray/binary conversion helpers.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_PTR_WIDTH  = 9;

  // Working width of the conversion helpers; callers zero-extend into it
  // and size-cast the result back to their pointer width.
  localparam int CODE_WIDTH = 32;

  typedef logic [CODE_WIDTH-1:0] code_t;

  // Binary to Gray over the low 'width' bits; upper bits are cleared.
  function automatic code_t bin2gray(input code_t bin, input int unsigned width);
    code_t mask;
    code_t masked;
    mask   = ~({CODE_WIDTH{1'b1}} << width);
    masked = bin & mask;
    return masked ^ (masked >> 1);
  endfunction

  // Gray to binary over the low 'width' bits; each binary bit is the XOR of
  // all Gray bits at or above it.
  function automatic code_t gray2bin(input code_t gray, input int unsigned width);
    code_t mask;
    code_t masked;
    code_t bin;
    mask   = ~({CODE_WIDTH{1'b1}} << width);
    masked = gray & mask;
    bin    = {CODE_WIDTH{1'b0}};
    for (int i = 0; i < CODE_WIDTH; i++) begin
      bin[i] = ^(masked >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
// The two stages sit back to back with no logic between them.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Capture the foreign-domain value, then let it settle one more stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO (rclk domain).
// Synchronizes the write Gray pointer, keeps the binary/Gray read pointer and
// registered empty flag, and feeds a one-entry valid/ready output stage.
// Optional build macro FIFO_RD_LEVEL_EN adds a registered fill-level output
// (rlevel) that counts words still in memory, excluding the output stage.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PTR_WIDTH  = FIFO_PTR_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [PTR_WIDTH:0]    wptr_gray,
  output logic [PTR_WIDTH:0]    rptr,
  output logic [PTR_WIDTH:0]    rptr_gray,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  read_enable,
  output logic                  rempty,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  rready
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [PTR_WIDTH:0]    rlevel
`endif
);

  localparam int PW1 = PTR_WIDTH + 1;

  logic [PTR_WIDTH:0]    wq2_gray_s;
  logic [PTR_WIDTH:0]    rptr_r;
  logic [PTR_WIDTH:0]    rptr_gray_r;
  logic                  rempty_r;
  logic                  rvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  pop_s;
  logic [PTR_WIDTH:0]    rbin_next_s;
  logic [PTR_WIDTH:0]    rgray_next_s;

  sync_2ff #(
    .WIDTH (PW1)
  ) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (wptr_gray),
    .q     (wq2_gray_s)
  );

  // Pop whenever memory holds a word and the output stage is free or draining.
  always_comb begin
    pop_s        = 1'b0;
    rbin_next_s  = rptr_r;
    rgray_next_s = rptr_gray_r;
    if (!rempty_r && (!rvalid_r || rready)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    rbin_next_s  = rptr_r + {{PTR_WIDTH{1'b0}}, pop_s};
    rgray_next_s = PW1'(bin2gray(code_t'(rbin_next_s), PW1));
  end

  // Advance both pointer encodings and derive empty from the next pointer so
  // the pop of the last word raises rempty on the same edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr_r      <= {PW1{1'b0}};
      rptr_gray_r <= {PW1{1'b0}};
      rempty_r    <= 1'b1;
    end else begin
      rptr_r      <= rbin_next_s;
      rptr_gray_r <= rgray_next_s;
      rempty_r    <= (rgray_next_s == wq2_gray_s);
    end
  end

  // One-entry output stage: load on pop, release on accept, otherwise hold.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rdata_r  <= {DATA_WIDTH{1'b0}};
      rvalid_r <= 1'b0;
    end else if (pop_s) begin
      rdata_r  <= mem_rdata;
      rvalid_r <= 1'b1;
    end else if (rready) begin
      rdata_r  <= rdata_r;
      rvalid_r <= 1'b0;
    end else begin
      rdata_r  <= rdata_r;
      rvalid_r <= rvalid_r;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_WIDTH:0] wq2_bin_s;
  logic [PTR_WIDTH:0] rlevel_r;

  // Decode the synchronized write pointer back to binary for the level.
  always_comb begin
    wq2_bin_s = {PW1{1'b0}};
    wq2_bin_s = PW1'(gray2bin(code_t'(wq2_gray_s), PW1));
  end

  // Words left in memory after this cycle's pop; modular difference covers wrap.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel_r <= {PW1{1'b0}};
    end else begin
      rlevel_r <= wq2_bin_s - rbin_next_s;
    end
  end

  assign rlevel = rlevel_r;
`endif

  assign read_enable = pop_s;
  assign rptr        = rptr_r;
  assign rptr_gray   = rptr_gray_r;
  assign rempty      = rempty_r;
  assign rvalid      = rvalid_r;
  assign rdata       = rdata_r;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl with a behavioural memory
// and write pointer driven by the bench.
module tb_fifo_rd_ctrl;

  logic       rclk;
  logic       rrst_n;
  logic [9:0] wptr_gray;
  logic [9:0] rptr;
  logic [9:0] rptr_gray;
  logic [7:0] mem_rdata;
  logic       read_enable;
  logic       rempty;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
`ifdef FIFO_RD_LEVEL_EN
  logic [9:0] rlevel;
`endif

  logic [7:0] mem [0:511];
  logic [7:0] q [$];
  logic [9:0] wbin;
  int         n_assert;
  int         n_fail;
  bit         seen_512;

  fifo_rd_ctrl #(
    .DATA_WIDTH (8),
    .PTR_WIDTH  (9)
  ) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .wptr_gray   (wptr_gray),
    .rptr        (rptr),
    .rptr_gray   (rptr_gray),
    .mem_rdata   (mem_rdata),
    .read_enable (read_enable),
    .rempty      (rempty),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .rready      (rready)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rlevel      (rlevel)
`endif
  );

  assign mem_rdata = mem[rptr[8:0]];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_wptr(input logic [9:0] v);
    wbin      = v;
    wptr_gray = v ^ (v >> 1);
  endtask

  task automatic push_words(input int n, input logic [7:0] start, input logic [7:0] step);
    logic [7:0] d;
    logic [9:0] b;
    b = wbin;
    for (int i = 0; i < n; i++) begin
      d = start + 8'(i) * step;
      mem[b[8:0]] = d;
      q.push_back(d);
      b = b + 10'd1;
    end
    set_wptr(b);
  endtask

  task automatic drain(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      if (rptr == 10'd512) seen_512 = 1'b1;
      if (rvalid) begin
        if (q.size() == 0) check({tag, " extra word"}, 32'd1, 32'd0);
        else check(tag, rdata, q.pop_front());
      end
      if (!rvalid && rempty && q.size() == 0) done = 1'b1;
    end
    check({tag, " drain timeout"}, done, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " rempty"}, rempty, 1);
    check({tag, " rvalid"}, rvalid, 0);
    check({tag, " rptr"}, rptr, 0);
    check({tag, " rptr_gray"}, rptr_gray, 0);
    check({tag, " rdata"}, rdata, 0);
    check({tag, " read_enable"}, read_enable, 0);
`ifdef FIFO_RD_LEVEL_EN
    check({tag, " rlevel"}, rlevel, 0);
`endif
  endtask

  initial begin
    int cnt;
    bit found;
    n_assert = 0;
    n_fail   = 0;
    seen_512 = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    rrst_n    = 1'b0;
    rready    = 1'b0;
    wbin      = 10'd0;
    wptr_gray = 10'h155;

    // Reset with a non-zero write pointer present.
    repeat (3) tick();
    check_reset_state("reset held");
    set_wptr(10'd0);
    rready = 1'b1;
    rrst_n = 1'b1;
    repeat (6) tick();
    check_reset_state("idle after release");

    // Single word: rempty falls at the third edge, one pop, one valid cycle.
    mem[0] = 8'hA5;
    set_wptr(10'd1);
    tick();
    check("single e1 rempty", rempty, 1);
    tick();
    check("single e2 rempty", rempty, 1);
    check("single e2 read_enable", read_enable, 0);
    tick();
    check("single e3 rempty", rempty, 0);
    check("single e3 read_enable", read_enable, 1);
    check("single e3 rvalid", rvalid, 0);
    tick();
    check("single e4 rvalid", rvalid, 1);
    check("single e4 rdata", rdata, 8'hA5);
    check("single e4 rptr", rptr, 1);
    check("single e4 rptr_gray", rptr_gray, 1);
    check("single e4 rempty", rempty, 1);
    check("single e4 read_enable", read_enable, 0);
    tick();
    check("single e5 rvalid", rvalid, 0);
    check("single e5 rdata hold", rdata, 8'hA5);

    // Burst of 16 from a fresh reset: 16 consecutive valid cycles.
    rrst_n = 1'b0;
    q.delete();
    set_wptr(10'd0);
    tick();
    rrst_n = 1'b1;
    tick();
    push_words(16, 8'h00, 8'h01);
    q.delete();
    repeat (3) tick();
    check("burst rempty low", rempty, 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("burst rvalid", rvalid, 1);
      check("burst rdata", rdata, 32'(k));
    end
    check("burst rptr", rptr, 16);
    check("burst rptr_gray", rptr_gray, 10'h018);
    check("burst rempty", rempty, 1);
    tick();
    check("burst rvalid end", rvalid, 0);

    // Wrap: 8 chunks of 73 words take the pointer from 16 to 600.
    for (int c = 0; c < 8; c++) begin
      push_words(73, 8'(c * 13 + 5), 8'h03);
      drain(90, "wrap rdata");
    end
    check("wrap passed 512", seen_512, 1);
    check("wrap rptr", rptr, 600);
    check("wrap rptr msb", rptr[9], 1);
    check("wrap rptr_gray", rptr_gray, 10'h374);
    check("wrap rempty", rempty, 1);

    // Stall: first word held while rready is low.
    rready = 1'b0;
    push_words(4, 8'hC0, 8'h01);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (rvalid) found = 1'b1;
    end
    check("stall rvalid timeout", found, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("stall rdata", rdata, 8'hC0);
      check("stall rptr", rptr, 601);
      check("stall rempty", rempty, 0);
      check("stall read_enable", read_enable, 0);
    end
    rready = 1'b1;
    #1;
    check("stall release read_enable", read_enable, 1);
    void'(q.pop_front());
    for (int k = 1; k < 4; k++) begin
      tick();
      check("stall drain rvalid", rvalid, 1);
      check("stall drain rdata", rdata, q.pop_front());
    end
    check("stall drain rptr", rptr, 604);
    check("stall drain rempty", rempty, 1);
    tick();
    check("stall drain done", rvalid, 0);

    // Reset in the middle of an 8-word burst, then re-aligned pointers.
    push_words(8, 8'h40, 8'h11);
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 3; c++) begin
      tick();
      if (rvalid) begin
        check("midrst rdata", rdata, q.pop_front());
        cnt++;
      end
    end
    check("midrst word count", cnt, 3);
    rrst_n = 1'b0;
    #1;
    check_reset_state("midrst asserted");
    q.delete();
    set_wptr(10'd5);
    tick();
    tick();
    check_reset_state("midrst held");
    rrst_n = 1'b1;
    for (int i = 0; i < 5; i++) q.push_back(mem[i]);
    tick();
    check("midrst e1 rempty", rempty, 1);
    tick();
    check("midrst e2 rempty", rempty, 1);
    tick();
    check("midrst e3 rempty", rempty, 0);
`ifdef FIFO_RD_LEVEL_EN
    check("midrst e3 rlevel", rlevel, 5);
    tick();
    check("midrst e4 rlevel", rlevel, 4);
    check("midrst e4 rdata", rdata, q.pop_front());
`endif
    drain(15, "midrst rdata");
    check("midrst final rptr", rptr, 5);
    check("midrst final rempty", rempty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller of the async FIFO; sits in the rclk domain opposite the dual-port memory's write port.
- Synchronizes the write-domain Gray pointer, maintains the binary/Gray read pointer and the registered empty flag.
- Presents memory words through a one-entry registered output stage with a valid/ready handshake.
- Exports its Gray read pointer for the write-side full logic.

Parameters:
- DATA_WIDTH, 8, word width; matches the memory data width.
- PTR_WIDTH, 9, address bits; depth = 2**PTR_WIDTH = 512; pointers carry PTR_WIDTH+1 bits including the wrap bit.

Ports:
- rclk  input  1  read clock.
- rrst_n  input  1  asynchronous active-low reset.
- wptr_gray  input  PTR_WIDTH+1  write pointer, Gray coded, launched from wclk; asynchronous to rclk.
- rptr  output  PTR_WIDTH+1  binary read pointer; the memory indexes with rptr[PTR_WIDTH-1:0].
- rptr_gray  output  PTR_WIDTH+1  registered Gray read pointer, sent to the write domain.
- mem_rdata  input  DATA_WIDTH  combinational memory output at rptr.
- read_enable  output  1  pop strobe; high for exactly the cycles the pointer advances.
- rempty  output  1  registered empty flag.
- rdata  output  DATA_WIDTH  output-stage data.
- rvalid  output  1  rdata holds a valid word.
- rready  input  1  consumer accepts rdata this cycle.

Behaviour:
- Reset (async assert, release synchronous to rclk):
  - rptr = 0, rptr_gray = 0, both synchronizer stages = 0.
  - rempty = 1, rvalid = 0, rdata = 0, read_enable = 0.
- Synchronizer: two flops on wptr_gray give wq2_gray; no logic between the stages.
- Pop condition: pop = !rempty && (!rvalid || rready). read_enable = pop, combinational.
- Pointer update:
  - rbin_next = rptr + pop, mod 2**(PTR_WIDTH+1).
  - rgray_next = rbin_next ^ (rbin_next >> 1).
  - Both pointers register on every rclk.
- Empty: rempty <= (rgray_next == wq2_gray). It is computed from the next pointer, so the last word's pop sets rempty in the same edge.
- Output stage:
  - On pop: rdata <= mem_rdata, rvalid <= 1.
  - Else if rready: rvalid <= 0 and rdata holds its value.
  - Else: hold.
  - Pop and drain in the same cycle gives back-to-back throughput of 1 word/cycle.
- Latency: a write edge that moves wptr_gray lowers rempty at the 3rd rclk edge after wptr_gray settles (2 sync + 1 flag). rvalid rises 1 cycle later.
- Wrap-around: the MSB toggles at each wrap. Full and empty are distinguished only by the write side; this block treats equal Gray pointers as empty.
- Stall: with rvalid=1 and rready=0 there is no pop; rptr and rdata are stable.
- Mid-operation reset: every register returns to its reset value immediately; an in-flight word is discarded.
- rempty deasserts late and never early; it is never 0 while the FIFO is empty.

Optional Feature:
- Macro: FIFO_RD_LEVEL_EN.
- Defined:
  - Adds output rlevel, width PTR_WIDTH+1, registered.
  - rlevel <= gray2bin(wq2_gray) - rbin_next, mod 2**(PTR_WIDTH+1); range 0..2**PTR_WIDTH.
  - Reset value 0. rlevel excludes the word held in the output stage.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package fifo_pkg:
  - bin2gray and gray2bin functions, parameterized by width.
  - Default DATA_WIDTH and PTR_WIDTH localparams shared with the write side.
- Sub-module sync_2ff:
  - Parameter WIDTH; ports clk, rst_n, d, q.
  - Two flops resetting to 0.
  - Instanced once here; reused by the write side.

Test Plan:
- Reset: hold rrst_n=0 with wptr_gray=0x155 → rempty=1, rvalid=0, rptr=0, rptr_gray=0. After release with wptr_gray=0 → these values hold indefinitely.
- Single word: memory[0]=0xA5, wptr_gray 0→1, rready=1 → rempty falls at edge 3, read_enable pulses once, rdata=0xA5 with rvalid=1 for one cycle. rptr=1, rempty=1 afterwards.
- Burst/back-to-back: 16 words 0x00..0x0F, rready=1 → rvalid high 16 consecutive cycles, data in order, final rptr=16, rptr_gray=0x18.
- Wrap: preset traffic to 600 words in/out in chunks → rptr passes 511→512 (addr 0, MSB=1), data integrity holds, rempty=1 when rptr=wptr=600.
- Stall: 4 words available, rready=0 for 5 cycles after rvalid → rdata, rptr and rempty stable. Releasing rready drains 4 words in 4 cycles.
- Reset mid-burst: assert rrst_n after word 3 of 8 → outputs return to reset values within the same cycle. With FIFO_RD_LEVEL_EN, rlevel=0 during reset and rlevel=5 three cycles after release with 8 written, 3 read, pointers re-aligned by the bench.
